// File: rtl/mtimer.sv
// RISC-V machine timer: prescaled 64-bit mtime, 64-bit mtimecmp, and a one-shot
// tip/tip_reply interrupt handshake, exposed as a small word-addressed peripheral.
module mtimer #(
    parameter int unsigned CLK_DIV = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  a,
    input  logic [31:0] d,
    input  logic        we,
    output logic [31:0] spo,
    output logic        tip,
    input  logic        tip_reply
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

    localparam logic [2:0] A_MTIME_LO = 3'd0;
    localparam logic [2:0] A_MTIME_HI = 3'd1;
    localparam logic [2:0] A_CMP_LO   = 3'd2;
    localparam logic [2:0] A_CMP_HI   = 3'd3;
    localparam logic [2:0] A_CTRL     = 3'd4;

    logic [PW-1:0] presc_q, presc_d;
    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic          en_q, en_d;
    logic          armed_q, armed_d;
    logic          tip_q, tip_d;

    logic wr_mtime, wr_cmp, tick, hit;

    always_comb begin
        wr_mtime = we && (a == A_MTIME_LO || a == A_MTIME_HI);
        wr_cmp   = we && (a == A_CMP_LO || a == A_CMP_HI);
        tick     = en_q && (presc_q == PRE_MAX);
        hit      = (mtime_q >= mtimecmp_q);
    end

    // A software write to mtime wins over a coincident tick so the stored value is exact.
    always_comb begin
        presc_d = presc_q;
        mtime_d = mtime_q;
        if (en_q) begin
            if (tick) begin
                presc_d = '0;
                mtime_d = mtime_q + 64'd1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
        if (wr_mtime) begin
            presc_d = '0;
            if (a == A_MTIME_LO) mtime_d = {mtime_q[63:32], d};
            else                 mtime_d = {d, mtime_q[31:0]};
        end
    end

    always_comb begin
        mtimecmp_d = mtimecmp_q;
        en_d       = en_q;
        if (we && a == A_CMP_LO) mtimecmp_d = {mtimecmp_q[63:32], d};
        if (we && a == A_CMP_HI) mtimecmp_d = {d, mtimecmp_q[31:0]};
        if (we && a == A_CTRL)   en_d = d[0];
    end

    // armed makes each compare event produce a single interrupt until software re-arms.
    always_comb begin
        tip_d   = tip_q;
        armed_d = armed_q;
        if (wr_cmp) begin
            tip_d   = 1'b0;
            armed_d = 1'b1;
        end else if (tip_reply) begin
            tip_d   = 1'b0;
            armed_d = 1'b0;
        end else if (armed_q && hit) begin
            tip_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            en_q       <= 1'b1;
            armed_q    <= 1'b1;
            tip_q      <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            en_q       <= en_d;
            armed_q    <= armed_d;
            tip_q      <= tip_d;
        end
    end

    always_comb begin
        spo = '0;
        case (a)
            A_MTIME_LO: spo = mtime_q[31:0];
            A_MTIME_HI: spo = mtime_q[63:32];
            A_CMP_LO:   spo = mtimecmp_q[31:0];
            A_CMP_HI:   spo = mtimecmp_q[63:32];
            A_CTRL:     spo = {29'd0, tip_q, armed_q, en_q};
            default:    spo = '0;
        endcase
    end

    assign tip = tip_q;

endmodule

// File: tb/tb_mtimer.sv
// Directed self-checking bench for mtimer with CLK_DIV=4.
module tb_mtimer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  a = '0;
    logic [31:0] d = '0;
    logic        we = 1'b0;
    logic [31:0] spo;
    logic        tip;
    logic        tip_reply = 1'b0;

    int tests = 0;
    int fails = 0;

    mtimer #(.CLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .a(a), .d(d), .we(we),
        .spo(spo), .tip(tip), .tip_reply(tip_reply)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] data);
        a = addr; d = data; we = 1'b1;
        step(1);
        we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] addr, output logic [31:0] data);
        a = addr;
        #1;
        data = spo;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        rd(0, v); tests++; if (v !== 32'h0) begin fails++; $display("FAIL reset_mtime_lo: got %h want %h", v, 32'h0); end
        rd(1, v); tests++; if (v !== 32'h0) begin fails++; $display("FAIL reset_mtime_hi: got %h want %h", v, 32'h0); end
        rd(2, v); tests++; if (v !== 32'hFFFF_FFFF) begin fails++; $display("FAIL reset_cmp_lo: got %h want %h", v, 32'hFFFF_FFFF); end
        rd(3, v); tests++; if (v !== 32'hFFFF_FFFF) begin fails++; $display("FAIL reset_cmp_hi: got %h want %h", v, 32'hFFFF_FFFF); end
        tests++; if (tip !== 1'b0) begin fails++; $display("FAIL reset_tip: got %b want 0", tip); end
    endtask

    task automatic test_count;
        logic [31:0] v;
        for (int c = 0; c < 4; c++) begin
            rd(0, v);
            tests++; if (v !== 32'h0) begin fails++; $display("FAIL count_cycle%0d: got %h want %h", c, v, 32'h0); end
            step(1);
        end
        rd(0, v); tests++; if (v !== 32'h1) begin fails++; $display("FAIL count_first_tick: got %h want %h", v, 32'h1); end
        step(36);
        rd(0, v); tests++; if (v !== 32'd10) begin fails++; $display("FAIL count_40_cycles: got %h want %h", v, 32'd10); end
        rd(4, v); tests++; if (v !== 32'h3) begin fails++; $display("FAIL count_ctrl: got %h want %h", v, 32'h3); end
    endtask

    task automatic test_carry;
        logic [31:0] v;
        wr(0, 32'hFFFF_FFFF);
        wr(1, 32'h0000_0005);
        step(3);
        rd(0, v); tests++; if (v !== 32'hFFFF_FFFF) begin fails++; $display("FAIL carry_before_lo: got %h want %h", v, 32'hFFFF_FFFF); end
        step(1);
        rd(0, v); tests++; if (v !== 32'h0) begin fails++; $display("FAIL carry_lo: got %h want %h", v, 32'h0); end
        rd(1, v); tests++; if (v !== 32'h6) begin fails++; $display("FAIL carry_hi: got %h want %h", v, 32'h6); end
        wr(0, 32'hFFFF_FFFF);
        wr(1, 32'hFFFF_FFFF);
        step(4);
        rd(0, v); tests++; if (v !== 32'h0) begin fails++; $display("FAIL wrap_lo: got %h want %h", v, 32'h0); end
        rd(1, v); tests++; if (v !== 32'h0) begin fails++; $display("FAIL wrap_hi: got %h want %h", v, 32'h0); end
    endtask

    task automatic test_compare;
        logic [31:0] v;
        bit found;
        bit stayed;
        wr(1, 32'h0);
        wr(0, 32'h0);
        wr(3, 32'h0);
        wr(2, 32'h3);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1);
            rd(0, v);
            if (v == 32'h3) found = 1'b1;
        end
        tests++; if (!found) begin fails++; $display("FAIL cmp_reach3: got %h want %h", v, 32'h3); end
        tests++; if (tip !== 1'b0) begin fails++; $display("FAIL cmp_tip_same_cycle: got %b want 0", tip); end
        step(1);
        tests++; if (tip !== 1'b1) begin fails++; $display("FAIL cmp_tip_rise: got %b want 1", tip); end
        rd(4, v); tests++; if (v !== 32'h7) begin fails++; $display("FAIL cmp_ctrl_pending: got %h want %h", v, 32'h7); end
        tip_reply = 1'b1;
        step(1);
        tip_reply = 1'b0;
        tests++; if (tip !== 1'b0) begin fails++; $display("FAIL reply_tip_fall: got %b want 0", tip); end
        stayed = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (tip !== 1'b0) stayed = 1'b0;
        end
        tests++; if (!stayed) begin fails++; $display("FAIL reply_tip_stays_low: got %b want 1", stayed); end
        rd(4, v); tests++; if (v !== 32'h1) begin fails++; $display("FAIL reply_ctrl: got %h want %h", v, 32'h1); end
    endtask

    task automatic test_rearm;
        logic [31:0] v;
        bit stayed;
        wr(2, 32'h1);
        tests++; if (tip !== 1'b0) begin fails++; $display("FAIL rearm_tip_write_edge: got %b want 0", tip); end
        rd(4, v); tests++; if (v !== 32'h3) begin fails++; $display("FAIL rearm_ctrl: got %h want %h", v, 32'h3); end
        step(1);
        tests++; if (tip !== 1'b1) begin fails++; $display("FAIL rearm_tip_rise: got %b want 1", tip); end
        wr(2, 32'hFFFF_FFFF);
        tests++; if (tip !== 1'b0) begin fails++; $display("FAIL rearm_far_tip_clear: got %b want 0", tip); end
        wr(3, 32'hFFFF_FFFF);
        stayed = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (tip !== 1'b0) stayed = 1'b0;
        end
        tests++; if (!stayed) begin fails++; $display("FAIL rearm_far_stays_low: got %b want 1", stayed); end
    endtask

    task automatic test_simultaneous;
        logic [31:0] v, prev;
        bit found;
        wr(3, 32'h0);
        wr(2, 32'h1);
        step(1);
        tests++; if (tip !== 1'b1) begin fails++; $display("FAIL simul_setup_tip: got %b want 1", tip); end
        tip_reply = 1'b1;
        wr(2, 32'h2);
        tip_reply = 1'b0;
        tests++; if (tip !== 1'b0) begin fails++; $display("FAIL simul_tip: got %b want 0", tip); end
        rd(4, v); tests++; if (v !== 32'h3) begin fails++; $display("FAIL simul_armed: got %h want %h", v, 32'h3); end
        step(1);
        tests++; if (tip !== 1'b1) begin fails++; $display("FAIL simul_tip_after: got %b want 1", tip); end
        // align to a tick: right after mtime changes the prescaler is 0
        rd(0, prev);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1);
            rd(0, v);
            if (v != prev) found = 1'b1;
        end
        tests++; if (!found) begin fails++; $display("FAIL tick_align: got %h want %h", v, prev + 32'd1); end
        step(3);
        wr(0, 32'h100);
        rd(0, v); tests++; if (v !== 32'h100) begin fails++; $display("FAIL wr_on_tick_lo: got %h want %h", v, 32'h100); end
        rd(1, v); tests++; if (v !== 32'h0) begin fails++; $display("FAIL wr_on_tick_hi: got %h want %h", v, 32'h0); end
        step(3);
        rd(0, v); tests++; if (v !== 32'h100) begin fails++; $display("FAIL presc_cleared_hold: got %h want %h", v, 32'h100); end
        step(1);
        rd(0, v); tests++; if (v !== 32'h101) begin fails++; $display("FAIL presc_cleared_tick: got %h want %h", v, 32'h101); end
    endtask

    task automatic test_enable;
        logic [31:0] v, frozen;
        wr(4, 32'h0);
        rd(0, frozen);
        step(20);
        rd(0, v); tests++; if (v !== frozen) begin fails++; $display("FAIL en_frozen: got %h want %h", v, frozen); end
        tests++; if (tip !== 1'b1) begin fails++; $display("FAIL en_tip_held: got %b want 1", tip); end
        rd(4, v); tests++; if (v !== 32'h6) begin fails++; $display("FAIL en_ctrl: got %h want %h", v, 32'h6); end
        wr(4, 32'h1);
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        wr(1, 32'h0);
        wr(0, 32'h1234);
        rd(0, v); tests++; if (v !== 32'h1234) begin fails++; $display("FAIL rstmid_setup_mtime: got %h want %h", v, 32'h1234); end
        tests++; if (tip !== 1'b1) begin fails++; $display("FAIL rstmid_setup_tip: got %b want 1", tip); end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        tests++; if (tip !== 1'b0) begin fails++; $display("FAIL rstmid_tip: got %b want 0", tip); end
        rd(0, v); tests++; if (v !== 32'h0) begin fails++; $display("FAIL rstmid_mtime: got %h want %h", v, 32'h0); end
        rd(3, v); tests++; if (v !== 32'hFFFF_FFFF) begin fails++; $display("FAIL rstmid_cmp_hi: got %h want %h", v, 32'hFFFF_FFFF); end
        rd(4, v); tests++; if (v !== 32'h3) begin fails++; $display("FAIL rstmid_ctrl: got %h want %h", v, 32'h3); end
    endtask

    task automatic test_reserved;
        logic [31:0] v;
        wr(5, 32'hDEAD_BEEF);
        wr(6, 32'h1234_5678);
        rd(5, v); tests++; if (v !== 32'h0) begin fails++; $display("FAIL rsv_read5: got %h want %h", v, 32'h0); end
        rd(6, v); tests++; if (v !== 32'h0) begin fails++; $display("FAIL rsv_read6: got %h want %h", v, 32'h0); end
        rd(2, v); tests++; if (v !== 32'hFFFF_FFFF) begin fails++; $display("FAIL rsv_cmp_untouched: got %h want %h", v, 32'hFFFF_FFFF); end
        wr(4, 32'hFFFF_FFF0);
        rd(4, v); tests++; if (v !== 32'h2) begin fails++; $display("FAIL ctrl_upper_ignored: got %h want %h", v, 32'h2); end
    endtask

    initial begin
        test_reset;
        test_count;
        test_carry;
        test_compare;
        test_rearm;
        test_simultaneous;
        test_enable;
        test_reset_mid;
        test_reserved;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mtimer.md
# mtimer

Memory-mapped RISC-V machine timer: a free-running 64-bit `mtime` advanced by a clock prescaler, a 64-bit `mtimecmp`, and the `tip`/`tip_reply` handshake that feeds the machine timer interrupt into the privilege/CSR block. It sits on the CPU data bus as a small word-addressed peripheral and drives `tip` directly into the privilege block. The privilege block gates `tip` with `mie.MTIE` and `mstatus.MIE`, and pulses `tip_reply` once the interrupt has been taken.

## Interface
- `CLK_DIV`, 50, clk cycles per `mtime` tick; legal range 1..65536; 1 = increment every cycle.
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `a`  in  3  word address: 0 mtime[31:0], 1 mtime[63:32], 2 mtimecmp[31:0], 3 mtimecmp[63:32], 4 ctrl; 5–7 reserved
- `d`  in  32  write data
- `we`  in  1  write strobe, one write per cycle at address `a`
- `spo`  out  32  combinational read data for address `a`
- `tip`  out  1  timer interrupt pending, registered level
- `tip_reply`  in  1  one-cycle acknowledge from privilege block

## Operation
- Reset values: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, prescaler=0, ctrl.en=1, armed=1, tip=0.
- ctrl (addr 4):
  - bit0 en, R/W.
  - bit1 armed, RO.
  - bit2 tip, RO.
  - bits[31:3] read 0, writes ignored.
- Reserved addresses read 0; writes to them are ignored.
- Prescaler:
  - Counts 0..CLK_DIV-1 while en=1.
  - The cycle it equals CLK_DIV-1 is a tick: the prescaler wraps to 0 and mtime increments by 1.
  - en=0 freezes both the prescaler and mtime.
- mtime:
  - Full 64-bit unsigned increment; carry from the low word into the high word occurs on the same edge.
  - 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
- Write to addr 0 or 1:
  - Replaces that half only; the other half is unchanged.
  - Clears the prescaler to 0.
  - Suppresses any tick in that cycle, so the written value is exactly what is stored.
- Write to addr 2 or 3:
  - Replaces that half only.
  - Sets armed=1 and forces tip=0 at that edge.
- Compare is 64-bit unsigned: hit = (mtime >= mtimecmp), evaluated on current register values.
- tip update at each edge, in priority order:
  1. mtimecmp write → tip=0, armed=1.
  2. tip_reply=1 → tip=0, armed=0.
  3. armed & hit → tip=1.
  4. Otherwise tip holds.
- While armed=0, tip stays 0 regardless of hit. Only a subsequent mtimecmp write re-arms, so one compare event yields exactly one interrupt.
- tip_reply while tip=0 still clears armed. This is required; the privilege block may reply late.
- Clearing en does not clear tip or armed.

## Timing
- spo: combinational from `a` and current registers, valid in the same cycle; no read side effects.
- Writes take effect at the edge where we=1; a read of the same address in the next cycle returns the new value.
- tip latency: tip rises at the first edge at which the registered mtime already satisfies mtime >= mtimecmp with armed=1. That is one cycle after mtime reaches mtimecmp, or one cycle after an mtimecmp write that lands at or below the current mtime.
- tip falls at the edge where tip_reply=1 is sampled, or at an mtimecmp write edge.
- The 64-bit read is not atomic; software reads hi, lo, hi and retries on mismatch.
- rst mid-count or mid-handshake: all state returns to reset values at that edge, and tip is 0 in the following cycle.

## Test plan
- Counting, CLK_DIV=4, after reset:
  - mtime reads 0 for cycles 0–3 and becomes 1 after the 4th edge.
  - After 40 cycles, mtime=10.
  - ctrl reads 0x3.
- Carry:
  - Write mtime lo=0xFFFFFFFF, hi=0x00000005.
  - After 4 cycles, lo=0 and hi=6.
  - Write both halves to all-ones; after one tick, both read 0.
- Compare and handshake:
  - Write mtimecmp hi=0, lo=3.
  - tip rises one cycle after mtime==3.
  - Pulse tip_reply: tip=0 next cycle, and it stays 0 for 100 cycles even though mtime>mtimecmp.
  - ctrl reads 0x1.
- Re-arm:
  - After the scenario above, write mtimecmp lo=1, which is already passed.
  - tip=0 on the write edge, then tip=1 on the next edge.
  - Write mtimecmp lo=0xFFFFFFFF, hi=0xFFFFFFFF: tip=0 and stays 0.
- Simultaneous events:
  - tip_reply and an mtimecmp-lo write in the same cycle: armed=1 and tip=0 at that edge.
  - mtime write coincident with a tick: the written value is stored and the prescaler is 0.
- Enable and reset:
  - Write ctrl=0: mtime frozen for 20 cycles and tip unchanged.
  - Assert rst with tip=1 and mtime=0x1234: the next cycle shows tip=0, mtime=0, mtimecmp all-ones, ctrl=0x3.
